// File: rtl/kanagawa_hal_fifo_stream_reader_if.sv
// kanagawa_hal_fifo_stream_reader_if
//
// Bundles the two handshakes of the stream reader:
//   - FIFO read side (show-ahead): fifo_empty, fifo_q, fifo_rdreq
//   - output stream side:          out_valid, out_data, out_ready
//
// Modports:
//   master - the reader: consumes the FIFO head and drives the stream.
//   slave  - the environment: presents the FIFO head and accepts the stream.
interface kanagawa_hal_fifo_stream_reader_if #(
  parameter int WIDTH = 32
);
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_q;
  logic             fifo_rdreq;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport master (
    input  fifo_empty,
    input  fifo_q,
    input  out_ready,
    output fifo_rdreq,
    output out_valid,
    output out_data
  );

  modport slave (
    output fifo_empty,
    output fifo_q,
    output out_ready,
    input  fifo_rdreq,
    input  out_valid,
    input  out_data
  );
endinterface

// File: rtl/kanagawa_hal_fifo_stream_reader.sv
// kanagawa_hal_fifo_stream_reader
//
// Drain-side adapter for a show-ahead FIFO. Pops words through the FIFO read
// port and presents them as a registered valid/ready stream. A two-entry
// buffer (head + skid) sustains one word per cycle while keeping fifo_rdreq
// independent of out_ready.
//
// Ports:
//   clock      - sole clock, rising edge
//   rst        - synchronous reset, active-high
//   bus        - FIFO read port and output stream (master modport)
//   buffered   - words held in the internal buffer, 0..2
//   xfer_count - words accepted downstream, wraps modulo 2^COUNT_WIDTH
module kanagawa_hal_fifo_stream_reader #(
  parameter int WIDTH       = 32,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                              clock,
  input  logic                              rst,
  kanagawa_hal_fifo_stream_reader_if.master bus,
  output logic [1:0]                        buffered,
  output logic [COUNT_WIDTH-1:0]            xfer_count
);

  logic [1:0]             count_reg;
  logic [WIDTH-1:0]       head_reg;
  logic [WIDTH-1:0]       skid_reg;
  logic [COUNT_WIDTH-1:0] xfer_count_reg;

  logic push;
  logic pop;

  // The pop request looks only at registered occupancy and the FIFO flag,
  // so out_ready never reaches fifo_rdreq combinationally.
  assign push = !rst && !bus.fifo_empty && (count_reg != 2'd2);
  assign pop  = (count_reg != 2'd0) && bus.out_ready;

  assign bus.fifo_rdreq = push;
  assign bus.out_valid  = (count_reg != 2'd0);
  assign bus.out_data   = head_reg;
  assign buffered       = count_reg;
  assign xfer_count     = xfer_count_reg;

  always_ff @(posedge clock) begin
    if (rst) begin
      count_reg      <= 2'd0;
      head_reg       <= '0;
      skid_reg       <= '0;
      xfer_count_reg <= '0;
    end else begin
      case (count_reg)
        2'd0: begin
          if (push) begin
            head_reg <= bus.fifo_q;
          end
        end
        2'd1: begin
          // With a simultaneous pop the incoming word goes straight to the
          // head; otherwise it waits in the skid slot behind the head.
          if (push && pop) begin
            head_reg <= bus.fifo_q;
          end else if (push) begin
            skid_reg <= bus.fifo_q;
          end
        end
        2'd2: begin
          if (pop) begin
            head_reg <= skid_reg;
          end
        end
        default: begin
        end
      endcase

      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase

      if (pop) begin
        xfer_count_reg <= xfer_count_reg + COUNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_kanagawa_hal_fifo_stream_reader.sv
module tb_kanagawa_hal_fifo_stream_reader;

  localparam int WIDTH = 32;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  always #5 clock = ~clock;

  kanagawa_hal_fifo_stream_reader_if #(.WIDTH(WIDTH)) bus ();
  kanagawa_hal_fifo_stream_reader_if #(.WIDTH(WIDTH)) bus4 ();

  logic [1:0]  buffered;
  logic [31:0] xfer_count;
  logic [1:0]  buffered4;
  logic [3:0]  xfer_count4;

  kanagawa_hal_fifo_stream_reader #(.WIDTH(WIDTH), .COUNT_WIDTH(32)) dut (
    .clock      (clock),
    .rst        (rst),
    .bus        (bus),
    .buffered   (buffered),
    .xfer_count (xfer_count)
  );

  // Narrow-counter instance fed the identical input stream, for wrap checks.
  assign bus4.fifo_empty = bus.fifo_empty;
  assign bus4.fifo_q     = bus.fifo_q;
  assign bus4.out_ready  = bus.out_ready;

  kanagawa_hal_fifo_stream_reader #(.WIDTH(WIDTH), .COUNT_WIDTH(4)) dut4 (
    .clock      (clock),
    .rst        (rst),
    .bus        (bus4),
    .buffered   (buffered4),
    .xfer_count (xfer_count4)
  );

  int tests = 0;
  int fails = 0;
  int pops  = 0;
  int cyc   = 0;
  bit verbose = 1'b1;

  logic [WIDTH-1:0] fifo_mem[$];
  logic [WIDTH-1:0] exp_q[$];

  bit rst_ctl     = 1'b1;
  bit rdy_ctl     = 1'b1;
  bit rdy_random  = 1'b0;
  int gap_pct     = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs on the falling edge, model the FIFO pop
  // once the combinational request has settled.
  task automatic step();
    @(negedge clock);
    rst = rst_ctl;
    bus.out_ready = rdy_random ? ($urandom_range(0, 3) != 0) : rdy_ctl;
    if (fifo_mem.size() == 0 || (gap_pct != 0 && $urandom_range(0, 99) < gap_pct)) begin
      bus.fifo_empty = 1'b1;
      bus.fifo_q     = $urandom;
    end else begin
      bus.fifo_empty = 1'b0;
      bus.fifo_q     = fifo_mem[0];
    end
    #1;
    if (rst) check("rdreq_in_reset", bus.fifo_rdreq, 0);
    if (bus.fifo_rdreq) begin
      if (bus.fifo_empty || buffered == 2'd2) begin
        check("rdreq_illegal", 1, 0);
      end else begin
        exp_q.push_back(fifo_mem.pop_front());
        pops++;
      end
    end
    cyc++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain(input string name, input int budget);
    int k;
    k = 0;
    while ((fifo_mem.size() != 0 || exp_q.size() != 0) && k < budget) begin
      step();
      k++;
    end
    if (fifo_mem.size() != 0 || exp_q.size() != 0) check(name, 1, 0);
  endtask

  // Monitor: compares every accepted word against the scoreboard and checks
  // that a stalled word is held unchanged.
  initial begin : monitor
    bit               hold_pending;
    logic [WIDTH-1:0] hold_data;
    logic [WIDTH-1:0] e;
    hold_pending = 1'b0;
    hold_data    = '0;
    forever begin
      @(negedge clock);
      #2;
      if (!rst && hold_pending) begin
        check("stall_valid", bus.out_valid, 1);
        check("stall_data", bus.out_data, hold_data);
      end
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", bus.out_data, e);
          if (verbose) $display("[TB] word 0x%0h expected 0x%0h cycle %0d", bus.out_data, e, cyc);
        end
      end
      hold_pending = !rst && bus.out_valid && !bus.out_ready;
      hold_data    = bus.out_data;
    end
  end

  initial begin : main
    int p0;
    bus.fifo_empty = 1'b1;
    bus.fifo_q     = '0;
    bus.out_ready  = 1'b0;

    // Reset with a non-empty FIFO; stream 1..8 afterwards.
    for (int i = 1; i <= 8; i++) fifo_mem.push_back(WIDTH'(i));
    rst_ctl = 1'b1;
    rdy_ctl = 1'b1;
    steps(3);
    rst_ctl = 1'b0;
    step();
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_out_data", bus.out_data, 0);
    check("reset_buffered", buffered, 0);
    check("reset_xfer_count", xfer_count, 0);
    check("first_rdreq", bus.fifo_rdreq, 1);
    steps(8);
    check("stream_xfer_7", xfer_count, 7);
    step();
    check("stream_xfer_8", xfer_count, 8);
    check("stream_drained", exp_q.size(), 0);

    // Backpressure: absorb exactly two words, then release.
    p0 = pops;
    fifo_mem.push_back(32'hA);
    fifo_mem.push_back(32'hB);
    fifo_mem.push_back(32'hC);
    rdy_ctl = 1'b0;
    steps(4);
    check("bp_pops", pops - p0, 2);
    check("bp_buffered", buffered, 2);
    check("bp_out_valid", bus.out_valid, 1);
    check("bp_out_data", bus.out_data, 32'hA);
    check("bp_rdreq_blocked", bus.fifo_rdreq, 0);
    rdy_ctl = 1'b1;
    step();
    check("bp_rdreq_first_pop", bus.fifo_rdreq, 0);
    step();
    check("bp_rdreq_reassert", bus.fifo_rdreq, 1);
    drain("bp_drain_timeout", 20);
    check("bp_pops_total", pops - p0, 3);
    check("bp_xfer", xfer_count, 11);

    // Random gaps and random backpressure over 10000 words.
    verbose = 1'b0;
    for (int i = 0; i < 10000; i++) fifo_mem.push_back($urandom);
    gap_pct    = 25;
    rdy_random = 1'b1;
    drain("random_drain_timeout", 45000);
    gap_pct    = 0;
    rdy_random = 1'b0;
    rdy_ctl    = 1'b1;
    steps(2);
    check("random_xfer", xfer_count, 10011);
    check("random_buffered", buffered, 0);
    verbose = 1'b1;

    // Counter wrap: 17 transfers on the 4-bit counter.
    rst_ctl = 1'b1;
    step();
    rst_ctl = 1'b0;
    for (int i = 0; i < 17; i++) fifo_mem.push_back(32'h100 + WIDTH'(i));
    steps(19);
    check("wrap_xfer_wide", xfer_count, 17);
    check("wrap_xfer_narrow", xfer_count4, 1);
    check("wrap_drained", exp_q.size(), 0);

    // Reset while two words are buffered.
    fifo_mem.push_back(32'h11);
    fifo_mem.push_back(32'h22);
    fifo_mem.push_back(32'h33);
    rdy_ctl = 1'b0;
    steps(3);
    check("mid_buffered_full", buffered, 2);
    rst_ctl = 1'b1;
    exp_q.delete();
    fifo_mem.delete();
    step();
    rst_ctl = 1'b0;
    step();
    check("mid_out_valid", bus.out_valid, 0);
    check("mid_buffered", buffered, 0);
    check("mid_xfer", xfer_count, 0);
    fifo_mem.push_back(32'h44);
    fifo_mem.push_back(32'h55);
    rdy_ctl = 1'b1;
    drain("mid_drain_timeout", 20);
    steps(2);
    check("mid_xfer_after", xfer_count, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
